// File: rtl/axi_stream_crc_pkg.sv
`default_nettype none
//==============================================================================
// Module : axi_stream_crc_pkg
// Brief  : Shared types and constants for the CRC-append datapath arbiter.
// Rev    : 1.0 - initial release
//==============================================================================
package axi_stream_crc_pkg;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    PASS = 1'b1
  } arb_state_t;

  localparam int unsigned c_PKT_CNT_W = 16;

  // Never collapses to zero width, so a one-source build still elaborates.
  function automatic int unsigned src_width(input int unsigned num_src);
    return (num_src > 1) ? $clog2(num_src) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/axi_stream_rr_pick.sv
`default_nettype none
//==============================================================================
// Module : axi_stream_rr_pick
// Brief  : Combinational round-robin picker, scanning from last_grant+1.
// Rev    : 1.0 - initial release
//==============================================================================
module axi_stream_rr_pick
  import axi_stream_crc_pkg::*;
#(
  parameter int NUM_SRC = 4,
  parameter int SRC_W   = src_width(NUM_SRC)
) (
  input  logic [NUM_SRC-1:0] i_req,
  input  logic [SRC_W-1:0]   i_last_grant,
  output logic [SRC_W-1:0]   o_grant,
  output logic               o_any_req
);

  logic [SRC_W-1:0] w_idx;
  logic [SRC_W-1:0] w_grant;
  logic             w_found;

  always_comb begin
    w_idx   = i_last_grant;
    w_grant = i_last_grant;
    w_found = 1'b0;
    for (int off = 0; off < NUM_SRC; off++) begin
      w_idx = (w_idx == SRC_W'(NUM_SRC - 1)) ? '0 : w_idx + 1'b1;
      if (!w_found && i_req[w_idx]) begin
        w_grant = w_idx;
        w_found = 1'b1;
      end
    end
  end

  assign o_grant   = w_grant;
  assign o_any_req = w_found;

endmodule
`default_nettype wire

// File: rtl/axi_stream_crc_arbiter.sv
`default_nettype none
//==============================================================================
// Module : axi_stream_crc_arbiter
// Brief  : Packet-granular round-robin arbiter feeding one CRC-append stage.
//          Define CRC_ARB_PKT_CNT_EN for per-source packet counters (o_pkt_cnt).
// Rev    : 1.0 - initial release
//==============================================================================
module axi_stream_crc_arbiter
  import axi_stream_crc_pkg::*;
#(
  parameter int NUM_SRC    = 4,
  parameter int DATA_WIDTH = 512,
  parameter int KEEP_BYTES = DATA_WIDTH / 8,
  parameter int CRC_WIDTH  = 32,
  parameter int SRC_W      = src_width(NUM_SRC)
) (
  input  logic                            clk,
  input  logic                            srst,
  input  logic [NUM_SRC*DATA_WIDTH-1:0]   i_s_tdata,
  input  logic [NUM_SRC*KEEP_BYTES-1:0]   i_s_tkeep,
  input  logic [NUM_SRC-1:0]              i_s_tlast,
  input  logic [NUM_SRC-1:0]              i_s_tvalid,
  output logic [NUM_SRC-1:0]              o_s_tready,
  input  logic [NUM_SRC*CRC_WIDTH-1:0]    i_crc,
  output logic [DATA_WIDTH-1:0]           o_m_tdata,
  output logic [KEEP_BYTES-1:0]           o_m_tkeep,
  output logic                            o_m_tlast,
  output logic                            o_m_tvalid,
  output logic [CRC_WIDTH-1:0]            o_m_crc,
  output logic [SRC_W-1:0]                o_m_tid,
  input  logic                            i_m_tready
`ifdef CRC_ARB_PKT_CNT_EN
  ,
  output logic [NUM_SRC*c_PKT_CNT_W-1:0]  o_pkt_cnt
`endif
);

  arb_state_t            r_state;
  logic [SRC_W-1:0]      r_grant;
  logic [SRC_W-1:0]      r_last_grant;
  logic [DATA_WIDTH-1:0] r_m_tdata;
  logic [KEEP_BYTES-1:0] r_m_tkeep;
  logic                  r_m_tlast;
  logic                  r_m_tvalid;
  logic [CRC_WIDTH-1:0]  r_m_crc;
  logic [SRC_W-1:0]      r_m_tid;

  logic [SRC_W-1:0]      w_pick;
  logic                  w_any_req;
  logic                  w_accept;
  logic                  w_xfer;
  logic                  w_sel_last;
  logic [NUM_SRC-1:0]    w_ready;

  logic [DATA_WIDTH-1:0] w_tdata_arr [NUM_SRC];
  logic [KEEP_BYTES-1:0] w_tkeep_arr [NUM_SRC];
  logic [CRC_WIDTH-1:0]  w_crc_arr   [NUM_SRC];

  generate
    for (genvar k = 0; k < NUM_SRC; k++) begin : g_slice
      assign w_tdata_arr[k] = i_s_tdata[k*DATA_WIDTH +: DATA_WIDTH];
      assign w_tkeep_arr[k] = i_s_tkeep[k*KEEP_BYTES +: KEEP_BYTES];
      assign w_crc_arr[k]   = i_crc[k*CRC_WIDTH +: CRC_WIDTH];
    end
  endgenerate

  axi_stream_rr_pick #(
    .NUM_SRC (NUM_SRC),
    .SRC_W   (SRC_W)
  ) u_pick (
    .i_req        (i_s_tvalid),
    .i_last_grant (r_last_grant),
    .o_grant      (w_pick),
    .o_any_req    (w_any_req)
  );

  // Output register is a one-deep skid: accept only when it is empty or draining.
  assign w_accept   = (r_state == PASS) && (!r_m_tvalid || i_m_tready);
  assign w_xfer     = w_accept && i_s_tvalid[r_grant];
  assign w_sel_last = i_s_tlast[r_grant];

  always_comb begin
    w_ready          = '0;
    w_ready[r_grant] = w_accept;
  end

  always_ff @(posedge clk or posedge srst) begin
    if (srst) begin
      r_state      <= IDLE;
      r_grant      <= '0;
      r_last_grant <= SRC_W'(NUM_SRC - 1);
      r_m_tdata    <= '0;
      r_m_tkeep    <= '0;
      r_m_tlast    <= 1'b0;
      r_m_tvalid   <= 1'b0;
      r_m_crc      <= '0;
      r_m_tid      <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_any_req) begin
            r_grant <= w_pick;
            r_state <= PASS;
          end
        end
        PASS: begin
          if (w_xfer && w_sel_last) begin
            r_last_grant <= r_grant;
            r_state      <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase

      if (w_xfer) begin
        r_m_tdata  <= w_tdata_arr[r_grant];
        r_m_tkeep  <= w_tkeep_arr[r_grant];
        r_m_tlast  <= w_sel_last;
        r_m_crc    <= w_crc_arr[r_grant];
        r_m_tid    <= r_grant;
        r_m_tvalid <= 1'b1;
      end else if (i_m_tready) begin
        r_m_tvalid <= 1'b0;
      end
    end
  end

  assign o_s_tready = w_ready;
  assign o_m_tdata  = r_m_tdata;
  assign o_m_tkeep  = r_m_tkeep;
  assign o_m_tlast  = r_m_tlast;
  assign o_m_tvalid = r_m_tvalid;
  assign o_m_crc    = r_m_crc;
  assign o_m_tid    = r_m_tid;

`ifdef CRC_ARB_PKT_CNT_EN
  generate
    for (genvar k = 0; k < NUM_SRC; k++) begin : g_pkt_cnt
      logic [c_PKT_CNT_W-1:0] r_cnt;
      always_ff @(posedge clk or posedge srst) begin
        if (srst) begin
          r_cnt <= '0;
        end else if (w_xfer && w_sel_last && (r_grant == SRC_W'(k))) begin
          r_cnt <= r_cnt + 1'b1;
        end
      end
      assign o_pkt_cnt[k*c_PKT_CNT_W +: c_PKT_CNT_W] = r_cnt;
    end
  endgenerate
`endif

endmodule
`default_nettype wire
